reg_rotator: RTL
================

# reg_rotator

Parametrised bank of DEPTH registers, each WIDTH bits wide, that permutes its contents in lock-step on the rising clock edge. It generalises the two-register non-blocking swap to N registers and four permutation modes. A start/busy/done handshake runs an exact number of steps, and a single write port loads the bank between runs. It serves as a test vehicle and utility block for exercising simultaneous-update (non-blocking) register behaviour in larger designs.

## Interface
Parameters:
- WIDTH, 8, bits per register (≥1)
- DEPTH, 4, number of registers (≥2; must be even when SWAP mode is used)
- CNTW, 8, width of the step-count input

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write r[wr_idx] <= wr_data; honoured only when not busy
- wr_idx  in  $clog2(DEPTH)  write index; values ≥ DEPTH are ignored
- wr_data  in  WIDTH  write data
- start  in  1  begin a run; sampled only in IDLE or DONE
- mode  in  2  0=ROTL, 1=ROTR, 2=SWAP, 3=REV; latched at start
- steps  in  CNTW  number of permutation edges in the run; latched at start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the final step
- q  out  DEPTH*WIDTH  all registers; r[i] at q[i*WIDTH +: WIDTH]

## Operation
- State machine has three states:
  - IDLE: start → RUN if steps≠0, otherwise → DONE.
  - RUN: each edge applies one permutation and decrements cnt; when cnt reaches 1 at an edge → DONE.
  - DONE: lasts one cycle; start → RUN/DONE as from IDLE, otherwise → IDLE.
- Permutations (all elements update simultaneously from pre-edge values):
  - ROTL: r[i] <= r[i-1], r[0] <= r[DEPTH-1].
  - ROTR: r[i] <= r[i+1], r[DEPTH-1] <= r[0].
  - SWAP: r[2k] <-> r[2k+1].
  - REV: r[i] <= r[DEPTH-1-i].
- Writes:
  - Applied in IDLE and DONE; ignored in RUN.
  - wr_en and start in the same cycle: the write lands at that edge, and the first permutation occurs at the following edge.
- Changes to mode or steps during RUN have no effect.
- Reset (asynchronous, any time, including mid-run):
  - All r[i]=0, cnt=0, state=IDLE, busy=0, done=0.
  - A run in progress is abandoned; no done pulse is issued.

## Timing
- start accepted at edge k with steps=N>0:
  - busy=1 from after edge k through edge k+N.
  - Permutations at edges k+1 … k+N.
  - done=1 for the cycle after edge k+N; busy=0 in that cycle.
- steps=0: no permutation; done=1 in the cycle after edge k; busy never asserts.
- Back-to-back run: start asserted during DONE is accepted at that edge, so there are no idle cycles between runs.
- busy and done are registered outputs decoded from state. q is the register contents directly, with no combinational path from inputs.
- Arithmetic: cnt is CNTW bits wide and only decrements, so it cannot wrap. Rotation indices wrap modulo DEPTH.

## Structure
- Shared package reg_rotator_pkg holds:
  - mode constants MODE_ROTL/ROTR/SWAP/REV;
  - state encoding ST_IDLE/ST_RUN/ST_DONE.
- Sub-module reg_rotator_perm: purely combinational permutation taking mode and the flat bus, producing the next flat bus. Generate loops only; parametrised by WIDTH and DEPTH.
- Top module contains the FSM, counter, write port and register bank.

## Test plan
- DEPTH=2, WIDTH=8; write r0=18, r1=0; ROTL with steps=3 → q alternates every edge and ends r0=0, r1=18. busy is high for exactly 3 cycles; a single done pulse follows.
- DEPTH=4; r=[1,2,3,4]; ROTR with steps=1 → [2,3,4,1]. Then REV with steps=1 → [1,4,3,2]. Then SWAP with steps=2 → unchanged [1,4,3,2].
- steps=0 → no change to q; done pulse one cycle after start; busy stays 0.
- wr_en asserted mid-run at index 0 with data 0xAA → ignored, and the run completes unaltered. wr_en together with start at index 0 (data 0x55) → 0x55 is written first, then rotated.
- Reset asserted asynchronously midway through a 10-step run → q=0, busy=0, no done pulse. A new start after reset is released behaves normally.
- start held high continuously with steps=2 → runs repeat with busy low only in the DONE cycles; mode changed mid-run takes effect only in the next run.

Source files
------------

// File: rtl/reg_rotator_pkg.sv
// reg_rotator_pkg: shared mode and state encodings for the register rotator.
package reg_rotator_pkg;

  // Permutation applied to the bank on each RUN edge.
  typedef enum logic [1:0] {
    MODE_ROTL = 2'd0,
    MODE_ROTR = 2'd1,
    MODE_SWAP = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_rotator_if.sv
// reg_rotator_if: write port, run handshake and bank read-back of reg_rotator.
//   master: drives wr_en/wr_idx/wr_data/start/mode/steps, observes busy/done/q
//   slave : the rotator itself
interface reg_rotator_if
  import reg_rotator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   wr_en;
  logic [IDXW-1:0]        wr_idx;
  logic [WIDTH-1:0]       wr_data;
  logic                   start;
  mode_e                  mode;
  logic [CNTW-1:0]        steps;
  logic                   busy;
  logic                   done;
  logic [DEPTH*WIDTH-1:0] q;

  modport master (
    output wr_en, wr_idx, wr_data, start, mode, steps,
    input  busy, done, q
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, start, mode, steps,
    output busy, done, q
  );

endinterface

// File: rtl/reg_rotator_perm.sv
// reg_rotator_perm: combinational permutation of a flat DEPTH x WIDTH bus.
//   mode_i  : permutation select
//   d_i     : current bank, element i at d_i[i*WIDTH +: WIDTH]
//   nxt_c_o : permuted bank (combinational)
module reg_rotator_perm
  import reg_rotator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  mode_e                  mode_i,
  input  logic [DEPTH*WIDTH-1:0] d_i,
  output logic [DEPTH*WIDTH-1:0] nxt_c_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_elem
    localparam int unsigned IU    = i;
    localparam int unsigned SRC_L = (IU + DEPTH - 1) % DEPTH;
    localparam int unsigned SRC_R = (IU + 1) % DEPTH;
    // An odd trailing element has no partner and keeps its value.
    localparam int unsigned SRC_S = ((IU ^ 1) < DEPTH) ? (IU ^ 1) : IU;
    localparam int unsigned SRC_V = DEPTH - 1 - IU;

    logic [WIDTH-1:0] sel_c;

    // Source element for this slot under each mode.
    always_comb begin
      sel_c = d_i[IU*WIDTH +: WIDTH];
      unique case (mode_i)
        MODE_ROTL: sel_c = d_i[SRC_L*WIDTH +: WIDTH];
        MODE_ROTR: sel_c = d_i[SRC_R*WIDTH +: WIDTH];
        MODE_SWAP: sel_c = d_i[SRC_S*WIDTH +: WIDTH];
        MODE_REV:  sel_c = d_i[SRC_V*WIDTH +: WIDTH];
        default:   sel_c = d_i[IU*WIDTH +: WIDTH];
      endcase
    end

    assign nxt_c_o[IU*WIDTH +: WIDTH] = sel_c;
  end

endmodule

// File: rtl/reg_rotator.sv
// reg_rotator: DEPTH x WIDTH register bank permuted in lock-step for a
// programmed number of edges, with a single write port between runs.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : write port, start/mode/steps, busy/done pulses, bank read-back q
module reg_rotator
  import reg_rotator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic         clk,
  input  logic         reset,
  reg_rotator_if.slave bus
);

  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BUSW = DEPTH * WIDTH;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;
  mode_e             mode_q,  mode_d;
  logic [BUSW-1:0]   bank_q,  bank_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [BUSW-1:0]   perm_c;

  // Next permutation of the bank under the latched mode.
  reg_rotator_perm #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_perm (
    .mode_i  (mode_q),
    .d_i     (bank_q),
    .nxt_c_o (perm_c)
  );

  // Next-state, counter, write port and bank update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    bank_d  = bank_q;

    unique case (state_q)
      ST_RUN: begin
        bank_d = perm_c;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE behave alike: write first, then sample start.
        if (bus.wr_en) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.wr_idx == IDXW'(i)) begin
              bank_d[i*WIDTH +: WIDTH] = bus.wr_data;
            end
          end
        end
        state_d = ST_IDLE;
        if (bus.start) begin
          mode_d  = bus.mode;
          cnt_d   = bus.steps;
          state_d = (bus.steps != '0) ? ST_RUN : ST_DONE;
        end
      end
    endcase

    // Status flags are registered copies of the next state's decode.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, counter, latched mode, bank and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_ROTL;
      bank_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      bank_q  <= bank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = bank_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
